// File: rtl/tick_tock_detector_if.sv
// tick_tock_detector_if: audio line in, beat/tone status out.
//   audio_in       : square-wave audio line, asynchronous to the detector clock
//   tone_active    : a confirmed tone is present
//   tone_is_tock   : type of current/most recent tone (0 tick, 1 tock)
//   beat_pulse     : one-cycle strobe per tone confirmation
//   beat_interval  : cycles between the last two beat pulses (saturating)
//   interval_valid : beat_interval holds a real measurement
//   seq_error      : strobe with beat_pulse when the beat repeats the previous type
//   beat_count     : beats since reset, wrapping
// master = audio source / beat consumer, slave = detector.
interface tick_tock_detector_if;
  logic        audio_in;
  logic        tone_active;
  logic        tone_is_tock;
  logic        beat_pulse;
  logic [31:0] beat_interval;
  logic        interval_valid;
  logic        seq_error;
  logic [15:0] beat_count;

  modport master (
    output audio_in,
    input  tone_active, tone_is_tock, beat_pulse, beat_interval,
           interval_valid, seq_error, beat_count
  );

  modport slave (
    input  audio_in,
    output tone_active, tone_is_tock, beat_pulse, beat_interval,
           interval_valid, seq_error, beat_count
  );
endinterface

// File: rtl/tick_tock_detector.sv
// tick_tock_detector: measures the period between rising edges of a square
// wave audio line and confirms tick / tock tones, emitting one beat event per
// confirmed tone with the tone type and the interval since the previous beat.
//   basys_clk : system clock
//   reset_n   : asynchronous active-low reset
//   bus       : audio input and beat/tone outputs (slave side)
// Latency: audio sampled at edge E0 -> sync E1 -> edge detect E2 -> outputs E3.
module tick_tock_detector #(
  parameter int TICK_PERIOD    = 62500,
  parameter int TOCK_PERIOD    = 125000,
  parameter int TOL            = 1250,
  parameter int LOCK_COUNT     = 4,
  parameter int SILENCE_CYCLES = 250000
) (
  input logic                 basys_clk,
  input logic                 reset_n,
  tick_tock_detector_if.slave bus
);
  localparam int PW = $clog2(SILENCE_CYCLES + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] SIL_V   = PW'(SILENCE_CYCLES);
  localparam logic [MW-1:0] LOCK_V  = MW'(LOCK_COUNT);
  localparam logic [31:0]   TICK_LO = 32'(TICK_PERIOD - TOL);
  localparam logic [31:0]   TICK_HI = 32'(TICK_PERIOD + TOL);
  localparam logic [31:0]   TOCK_LO = 32'(TOCK_PERIOD - TOL);
  localparam logic [31:0]   TOCK_HI = 32'(TOCK_PERIOD + TOL);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync_q;
  logic            edge_q;
  logic [PW-1:0]   period_cnt_q, period_cnt_d;
  logic [MW-1:0]   match_q, match_d;
  logic            cand_q, cand_d;
  logic            tone_q, tone_d;
  logic            tock_q, tock_d;
  logic            beat_q, beat_d;
  logic            serr_q, serr_d;
  logic            have_beat_q;
  logic            valid_q, valid_d;
  logic [31:0]     interval_cnt_q, interval_cnt_d;
  logic [31:0]     beat_interval_q, beat_interval_d;
  logic [15:0]     beat_count_q;

  // Synchronizer (sync_q[1:0]) plus one delayed copy for the edge detect.
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.audio_in};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  logic        at_sil, is_tick, is_tock, cls_ok, cls_tock;
  logic [31:0] per32;

  assign at_sil   = (period_cnt_q == SIL_V);
  assign per32    = 32'(period_cnt_q);
  assign is_tick  = (per32 >= TICK_LO) && (per32 <= TICK_HI);
  assign is_tock  = (per32 >= TOCK_LO) && (per32 <= TOCK_HI);
  assign cls_ok   = is_tick | is_tock;
  assign cls_tock = ~is_tick & is_tock;

  always_comb begin
    state_d         = state_q;
    match_d         = match_q;
    cand_d          = cand_q;
    tone_d          = tone_q;
    tock_d          = tock_q;
    beat_d          = 1'b0;
    serr_d          = 1'b0;
    period_cnt_d    = edge_q ? PW'(1) : (at_sil ? period_cnt_q : period_cnt_q + 1'b1);

    if (edge_q && (state_q == IDLE || at_sil)) begin
      // First edge of a burst (also when it coincides with the silence timeout).
      state_d = ACQUIRE;
      if (at_sil) begin
        match_d = '0;
        tone_d  = 1'b0;
      end
    end else if (at_sil) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        match_d = '0;
        tone_d  = 1'b0;
      end
    end else if (edge_q) begin
      if (!cls_ok)                 match_d = '0;
      else if (cls_tock == cand_q) match_d = (match_q == LOCK_V) ? match_q : match_q + 1'b1;
      else begin
        match_d = MW'(1);
        cand_d  = cls_tock;
      end
      unique case (state_q)
        ACQUIRE: if (match_d == LOCK_V) begin
          state_d = TONE;
          beat_d  = 1'b1;
          tone_d  = 1'b1;
          tock_d  = cand_d;
          // tock_q still holds the previous beat's type here.
          serr_d  = have_beat_q & (cand_d == tock_q);
        end
        TONE: if (!cls_ok || cls_tock != cand_q) begin
          state_d = ACQUIRE;
          tone_d  = 1'b0;
        end
        default: ;
      endcase
    end

    interval_cnt_d  = beat_d ? 32'd1 : ((&interval_cnt_q) ? interval_cnt_q : interval_cnt_q + 32'd1);
    beat_interval_d = beat_d ? interval_cnt_q : beat_interval_q;
    valid_d         = valid_q | (beat_d & have_beat_q);
  end

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      period_cnt_q    <= '0;
      match_q         <= '0;
      cand_q          <= 1'b0;
      tone_q          <= 1'b0;
      tock_q          <= 1'b0;
      beat_q          <= 1'b0;
      serr_q          <= 1'b0;
      have_beat_q     <= 1'b0;
      valid_q         <= 1'b0;
      interval_cnt_q  <= '0;
      beat_interval_q <= '0;
      beat_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      match_q         <= match_d;
      cand_q          <= cand_d;
      tone_q          <= tone_d;
      tock_q          <= tock_d;
      beat_q          <= beat_d;
      serr_q          <= serr_d;
      have_beat_q     <= have_beat_q | beat_d;
      valid_q         <= valid_d;
      interval_cnt_q  <= interval_cnt_d;
      beat_interval_q <= beat_interval_d;
      beat_count_q    <= beat_count_q + 16'(beat_d);
    end
  end

  assign bus.tone_active    = tone_q;
  assign bus.tone_is_tock   = tock_q;
  assign bus.beat_pulse     = beat_q;
  assign bus.beat_interval  = beat_interval_q;
  assign bus.interval_valid = valid_q;
  assign bus.seq_error      = serr_q;
  assign bus.beat_count     = beat_count_q;
endmodule

// File: tb/tb_tick_tock_detector.sv
// Bench for tick_tock_detector with small periods. An event-level model
// (edge timestamps, period = difference of timestamps) predicts the outputs
// and is compared every cycle; literal expectations pin the model's timing.
module tb_tick_tock_detector;
  localparam int TICK = 100, TOCK = 200, TOL = 4, LOCK = 4, SIL = 500;
  localparam longint MAX32 = 64'd4294967295;

  typedef struct packed {
    logic        act;
    logic        tock;
    logic        beat;
    logic [31:0] intv;
    logic        vld;
    logic        serr;
    logic [15:0] cnt;
  } outs_t;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  tick_tock_detector_if bus();

  tick_tock_detector #(
    .TICK_PERIOD(TICK), .TOCK_PERIOD(TOCK), .TOL(TOL),
    .LOCK_COUNT(LOCK), .SILENCE_CYCLES(SIL)
  ) dut (
    .basys_clk(gclk),
    .reset_n  (grst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int     cyc = 0;
  outs_t  exp_o = '0;
  logic   samp_prev;
  logic [2:0] rq;
  int     st;          // 0 idle, 1 acquiring, 2 tone
  int     match;
  logic   cand;
  int     nbeats;
  longint last_ev, last_beat;

  task automatic model_reset();
    exp_o = '0; samp_prev = 1'b0; rq = '0; st = 0; match = 0;
    cand = 1'b0; nbeats = 0; last_ev = 0; last_beat = 0;
  endtask

  always @(negedge grst_n) model_reset();

  always @(posedge gclk) begin
    logic   ev, rise, same;
    longint gap, d;
    int     cls;
    cyc = cyc + 1;
    if (!grst_n) model_reset();
    else begin
      // A rise sampled on this edge becomes a detected edge three edges later.
      rise = bus.audio_in & ~samp_prev;
      samp_prev = bus.audio_in;
      ev = rq[2];
      rq = {rq[1:0], rise};
      exp_o.beat = 1'b0;
      exp_o.serr = 1'b0;
      gap = longint'(cyc) - last_ev;
      if (ev) begin
        if (st == 0 || gap >= SIL) begin
          if (st != 0) begin match = 0; exp_o.act = 1'b0; end
          st = 1;
        end else begin
          cls = 0;
          if (gap - TICK <= TOL && TICK - gap <= TOL) cls = 1;
          else if (gap - TOCK <= TOL && TOCK - gap <= TOL) cls = 2;
          same = (cls != 0) && ((cls == 2) == cand);
          if (cls == 0) match = 0;
          else if (same) match = (match < LOCK) ? match + 1 : LOCK;
          else begin match = 1; cand = (cls == 2); end
          if (st == 1 && match == LOCK) begin
            st = 2;
            exp_o.beat = 1'b1;
            exp_o.act  = 1'b1;
            exp_o.serr = (nbeats > 0) && (cand == exp_o.tock);
            exp_o.tock = cand;
            nbeats++;
            exp_o.cnt = exp_o.cnt + 16'd1;
            if (nbeats >= 2) begin
              exp_o.vld = 1'b1;
              d = longint'(cyc) - last_beat;
              exp_o.intv = 32'((d > MAX32) ? MAX32 : d);
            end
            last_beat = cyc;
          end else if (st == 2 && !same) begin
            st = 1;
            exp_o.act = 1'b0;
          end
        end
        last_ev = cyc;
      end else if (st != 0 && gap >= SIL) begin
        st = 0; match = 0; exp_o.act = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int     beat_cyc[$];
  longint beat_int[$];
  logic   beat_tock[$], beat_serr[$], beat_vld[$];
  int     beat_cnt[$];
  int     fall_cyc = -1;
  logic   prev_act = 1'b0;

  function automatic outs_t dut_outs();
    outs_t o;
    o.act = bus.tone_active; o.tock = bus.tone_is_tock; o.beat = bus.beat_pulse;
    o.intv = bus.beat_interval; o.vld = bus.interval_valid;
    o.serr = bus.seq_error; o.cnt = bus.beat_count;
    return o;
  endfunction

  always @(negedge gclk) begin
    outs_t g, e;
    g = dut_outs();
    e = exp_o;
    if (!e.vld) begin g.intv = '0; e.intv = '0; end
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, g, e);
    end
    if (bus.beat_pulse === 1'b1) begin
      beat_cyc.push_back(cyc); beat_int.push_back(longint'(bus.beat_interval));
      beat_tock.push_back(bus.tone_is_tock); beat_serr.push_back(bus.seq_error);
      beat_vld.push_back(bus.interval_valid); beat_cnt.push_back(int'(bus.beat_count));
    end
    if (prev_act && !bus.tone_active) fall_cyc = cyc;
    prev_act = bus.tone_active;
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, longint got, longint expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  // One rising edge, then low for the rest of the period. Returns the cycle
  // index of the edge after which the rise was driven.
  task automatic rise(int period, output int k);
    k = cyc;
    bus.audio_in = 1'b1;
    step(period / 2);
    bus.audio_in = 1'b0;
    step(period - period / 2);
  endtask

  // n rises at one period; k5 is the 5th rise, klast the last.
  task automatic burst(int period, int n, output int k5, output int klast);
    int k;
    k5 = -1;
    for (int i = 0; i < n; i++) begin
      rise(period, k);
      if (i == LOCK) k5 = k;
      klast = k;
    end
  endtask

  initial begin
    int k5a, k5b, k5c, k5d, kl, k, nb;
    bus.audio_in = 1'b0;

    // Reset held while audio toggles: outputs stay zero.
    step(2);
    for (int i = 0; i < 6; i++) rise(TICK, k);
    chk("reset_outs_zero", longint'(dut_outs()), 0);
    chk("reset_no_beats", beat_cyc.size(), 0);
    step(10);
    grst_n = 1'b1;
    step(3);

    // Tick burst: one beat, registered 4 edges after the 5th rise is driven.
    burst(TICK, 20, k5a, kl);
    chk("tick_beats_once", beat_cyc.size(), 1);
    if (beat_cyc.size() >= 1) begin
      chk("tick_beat_time", beat_cyc[0], k5a + 4);
      chk("tick_beat_type", beat_tock[0], 0);
      chk("tick_beat_count", beat_cnt[0], 1);
      chk("tick_first_serr", beat_serr[0], 0);
    end
    // Silence: tone drops SIL cycles after the last detected edge.
    step(1000);
    chk("silence_fall_time", fall_cyc, kl + 4 + SIL);

    // Tock burst.
    burst(TOCK, 20, k5b, kl);
    chk("tock_beats", beat_cyc.size(), 2);
    if (beat_cyc.size() >= 2) begin
      chk("tock_beat_time", beat_cyc[1], k5b + 4);
      chk("tock_type", beat_tock[1], 1);
      chk("tock_serr", beat_serr[1], 0);
      chk("tock_valid", beat_vld[1], 1);
      chk("tock_interval", beat_int[1], k5b - k5a);
    end
    step(1000);

    // Tock -> tick is legal, tick -> tick flags a sequence error.
    burst(TICK, 6, k5c, kl);
    step(1000);
    burst(TICK, 6, k5d, kl);
    chk("tick_tick_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() >= 4) begin
      chk("alt_serr", beat_serr[2], 0);
      chk("repeat_serr", beat_serr[3], 1);
      chk("repeat_interval", beat_int[3], k5d - k5c);
    end
    step(1000);

    // Tolerance edges: 96/104 lock, 95/105 never, 100/200 alternating never.
    for (int i = 0; i < 5; i++) begin rise(96, k); rise(104, k); end
    chk("tol_in_locks", beat_cyc.size(), 5);
    step(1000);
    for (int i = 0; i < 5; i++) begin rise(95, k); rise(105, k); end
    step(1000);
    chk("tol_out_no_lock", beat_cyc.size(), 5);
    for (int i = 0; i < 5; i++) begin rise(TICK, k); rise(TOCK, k); end
    step(1000);
    chk("alternating_no_lock", beat_cyc.size(), 5);

    // Reset in the middle of a tone clears outputs asynchronously.
    for (int i = 0; i < 7; i++) rise(TICK, k);
    bus.audio_in = 1'b1;
    step(10);
    chk("tone_before_reset", bus.tone_active, 1);
    #1 grst_n = 1'b0;
    #1 chk("midtone_reset_zero", longint'(dut_outs()), 0);
    bus.audio_in = 1'b0;
    step(20);
    grst_n = 1'b1;
    step(3);
    nb = beat_cyc.size();
    burst(TICK, 5, k5a, kl);
    chk("post_reset_beat", beat_cyc.size(), nb + 1);
    if (beat_cyc.size() == nb + 1) begin
      chk("post_reset_time", beat_cyc[nb], k5a + 4);
      chk("post_reset_count", beat_cnt[nb], 1);
    end
    step(1000);

    // Counter wrap / saturation with counters pushed near their limits.
    #1;
    force dut.beat_count_q   = 16'hFFFF;
    force dut.interval_cnt_q = 32'hFFFF_FFF0;
    exp_o.cnt = 16'hFFFF;
    last_beat = longint'(cyc) + 2 - 64'd4294967280;
    step(1);
    #1;
    release dut.beat_count_q;
    release dut.interval_cnt_q;
    step(30);
    nb = beat_cyc.size();
    burst(TICK, 5, k5a, kl);
    chk("wrap_beat", beat_cyc.size(), nb + 1);
    if (beat_cyc.size() == nb + 1) begin
      chk("wrap_count", beat_cnt[nb], 0);
      chk("sat_interval", beat_int[nb], MAX32);
      chk("sat_valid", beat_vld[nb], 1);
    end
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
